// File: rtl/snitch_perf_sampler_pkg.sv
// Shared types for the performance-counter sampler: sample record, FSM states
// and the default register-interface request/response structs.
package snitch_perf_sampler_pkg;

  localparam int unsigned MaxCounters  = 16;
  localparam int unsigned IdxWidth     = $clog2(MaxCounters);
  localparam int unsigned SampleWidth  = 48;
  localparam int unsigned RegAddrWidth = 48;
  localparam int unsigned RegDataWidth = 64;

  // idx is sized for the largest supported sweep; smaller sweeps leave upper bits zero
  typedef struct packed {
    logic [7:0]             seq;
    logic [IdxWidth-1:0]    idx;
    logic [SampleWidth-1:0] value;
    logic                   error;
  } perf_sample_t;

  typedef enum logic [1:0] {Idle, Req, Out} sampler_state_e;

  typedef struct packed {
    logic [RegAddrWidth-1:0]   addr;
    logic                      write;
    logic [RegDataWidth-1:0]   wdata;
    logic [RegDataWidth/8-1:0] wstrb;
    logic                      valid;
  } sampler_reg_req_t;

  typedef struct packed {
    logic [RegDataWidth-1:0] rdata;
    logic                    error;
    logic                    ready;
  } sampler_reg_rsp_t;

endpackage

// File: rtl/snitch_perf_sampler_timer.sv
// Free-running period timer: fires once every period_i cycles while enabled,
// held at zero when disabled or when period_i is zero.
module snitch_perf_sampler_timer #(
  parameter int unsigned PeriodWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic [PeriodWidth-1:0] period_i,
  output logic                   fire_o
);

  logic [PeriodWidth-1:0] cnt_q;
  logic                   active;

  // >= rather than == so a period shrunk below the running count still fires
  always_comb begin
    active = enable_i && (period_i != '0);
    fire_o = active && (cnt_q >= period_i - PeriodWidth'(1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (!active || fire_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PeriodWidth'(1);
    end
  end

endmodule

// File: rtl/snitch_perf_cnt_sampler.sv
// Sweeps the cluster performance counters over the register interface, one read
// per counter, and streams each result out as a (seq, idx, value, error) record.
module snitch_perf_cnt_sampler
  import snitch_perf_sampler_pkg::*;
#(
  parameter int unsigned          NumCounters = MaxCounters,
  parameter int unsigned          AddrWidth   = RegAddrWidth,
  parameter int unsigned          DataWidth   = RegDataWidth,
  parameter logic [AddrWidth-1:0] CntBaseAddr = '0,
  parameter int unsigned          CntStride   = 8,
  parameter int unsigned          PeriodWidth = 32,
  parameter type                  reg_req_t   = sampler_reg_req_t,
  parameter type                  reg_rsp_t   = sampler_reg_rsp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic [PeriodWidth-1:0] period_i,
  input  logic                   trigger_i,
  output reg_req_t               reg_req_o,
  input  reg_rsp_t               reg_rsp_i,
  output perf_sample_t           sample_o,
  output logic                   sample_valid_o,
  input  logic                   sample_ready_i,
  output logic                   busy_o,
  output logic [15:0]            overrun_o
);

  sampler_state_e      state_q;
  logic [IdxWidth-1:0] idx_q;
  logic [7:0]          seq_q;
  perf_sample_t        sample_q;
  logic [15:0]         overrun_q;
  logic                timer_fire;
  logic                trig;
  logic                last;
  logic                unused_rdata;

  snitch_perf_sampler_timer #(
    .PeriodWidth(PeriodWidth)
  ) i_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .enable_i(enable_i),
    .period_i(period_i),
    .fire_o  (timer_fire)
  );

  assign trig         = enable_i && (trigger_i || timer_fire);
  assign last         = (idx_q == IdxWidth'(NumCounters - 1));
  assign unused_rdata = ^reg_rsp_i.rdata[DataWidth-1:SampleWidth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= Idle;
      idx_q     <= '0;
      seq_q     <= '0;
      sample_q  <= '0;
      overrun_q <= '0;
    end else begin
      // any trigger outside Idle is dropped, including one on the final accept
      if (trig && (state_q != Idle) && (overrun_q != 16'hFFFF)) begin
        overrun_q <= overrun_q + 16'd1;
      end
      unique case (state_q)
        Idle: begin
          if (trig) begin
            idx_q   <= '0;
            state_q <= Req;
          end
        end
        Req: begin
          if (reg_rsp_i.ready) begin
            sample_q.seq   <= seq_q;
            sample_q.idx   <= idx_q;
            sample_q.value <= reg_rsp_i.rdata[SampleWidth-1:0];
            sample_q.error <= reg_rsp_i.error;
            state_q        <= Out;
          end
        end
        Out: begin
          if (sample_ready_i) begin
            if (last) begin
              seq_q   <= seq_q + 8'd1;
              state_q <= Idle;
            end else begin
              idx_q   <= idx_q + IdxWidth'(1);
              state_q <= Req;
            end
          end
        end
        default: state_q <= Idle;
      endcase
    end
  end

  always_comb begin
    reg_req_o       = '0;
    reg_req_o.valid = (state_q == Req);
    reg_req_o.addr  = CntBaseAddr + AddrWidth'(idx_q) * AddrWidth'(CntStride);
  end

  assign sample_o       = sample_q;
  assign sample_valid_o = (state_q == Out);
  assign busy_o         = (state_q != Idle);
  assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_snitch_perf_cnt_sampler.sv
// Directed bench for the counter sampler: a 4-counter sweep against a behavioural
// register responder, plus stall, error, overrun, reset and timer sequences.
module tb_snitch_perf_cnt_sampler;
  import snitch_perf_sampler_pkg::*;

  localparam int unsigned NCnt = 4;
  localparam logic [47:0] Base = 48'h1000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             trigger = 1'b0;
  logic             sample_ready = 1'b1;
  logic [31:0]      period = '0;
  sampler_reg_req_t req;
  sampler_reg_rsp_t rsp;
  perf_sample_t     sample;
  logic             sample_valid;
  logic             busy;
  logic [15:0]      overrun;

  always #5 clk = ~clk;

  snitch_perf_cnt_sampler #(
    .NumCounters(NCnt),
    .CntBaseAddr(Base),
    .CntStride  (8)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .enable_i      (enable),
    .period_i      (period),
    .trigger_i     (trigger),
    .reg_req_o     (req),
    .reg_rsp_i     (rsp),
    .sample_o      (sample),
    .sample_valid_o(sample_valid),
    .sample_ready_i(sample_ready),
    .busy_o        (busy),
    .overrun_o     (overrun)
  );

  // responder: ready after lat waiting cycles, rdata = idx*100, optional error index
  int          lat = 0, hold = 0, err_idx = -1, wcnt = 0, cyc = 0;
  logic [47:0] ridx;
  always_comb begin
    rsp  = '0;
    ridx = (req.addr - Base) >> 3;
    if (req.valid && hold == 0 && wcnt >= lat) begin
      rsp.ready = 1'b1;
      rsp.rdata = 64'(ridx) * 64'd100;
      rsp.error = (int'(ridx) == err_idx);
    end
  end

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    wcnt <= (!req.valid || rsp.ready) ? 0 : wcnt + 1;
  end

  perf_sample_t got_q[$];
  logic [47:0]  addr_q[$];
  int           start_q[$];
  int           overlap = 0;
  logic         busy_d = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (sample_valid && sample_ready) got_q.push_back(sample);
      if (req.valid && rsp.ready) addr_q.push_back(req.addr);
      if (sample_valid && req.valid) overlap++;
      if (busy && !busy_d) start_q.push_back(cyc);
    end
    busy_d = busy;
  end

  typedef struct {
    int     idx;
    longint value;
    bit     err;
    int     seq;
  } exp_t;
  exp_t tbl[12];

  int errors = 0, checks = 0;

  task automatic chk(string nm, longint unsigned act, longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic wait_samples(int n, int budget, string nm);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(nm, got_q.size(), n);
  endtask

  task automatic wait_valid(string nm);
    int k = 0;
    while (!sample_valid && k < 50) begin
      tick();
      k++;
    end
    chk(nm, sample_valid, 1);
  endtask

  task automatic cmp_row(int g, int r);
    if (g >= got_q.size()) begin
      checks++;
      errors++;
      $display("FAIL row%0d: sample %0d missing, only %0d received", r, g, got_q.size());
      return;
    end
    chk($sformatf("row%0d_idx", r), got_q[g].idx, tbl[r].idx);
    chk($sformatf("row%0d_value", r), got_q[g].value, tbl[r].value);
    chk($sformatf("row%0d_err", r), got_q[g].error, tbl[r].err);
    chk($sformatf("row%0d_seq", r), got_q[g].seq, tbl[r].seq);
  endtask

  initial begin
    perf_sample_t snap;
    int bad, noreq, cur, n0, g0;

    // three sweeps: plain, error on idx 2, overrun-stressed
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 4; i++)
        tbl[s*4+i] = '{idx: i, value: i * 100, err: (s == 1 && i == 2), seq: s};

    repeat (3) tick();
    chk("rst_req_valid", req.valid, 0);
    chk("rst_req_write", req.write, 0);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_sample", sample, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    tick();

    // sweep 0: responder latency 2
    lat = 2;
    pulse();
    chk("lat_req_valid", req.valid, 1);
    chk("lat_busy", busy, 1);
    chk("lat_addr0", req.addr, Base);
    wait_samples(4, 100, "sweep0_count");
    chk("sweep0_busy_end", busy, 0);
    for (int i = 0; i < 4; i++) begin
      cmp_row(i, i);
      if (i < addr_q.size()) chk($sformatf("sweep0_addr%0d", i), addr_q[i], Base + 48'(8 * i));
    end

    // sweep 1: zero latency, error on idx 2, consumer stalls on idx 1
    lat = 0;
    err_idx = 2;
    sample_ready = 1'b0;
    pulse();
    for (int k = 0; k < 4; k++) begin
      wait_valid($sformatf("sweep1_valid%0d", k));
      cur = int'(sample.idx);
      if (cur == 1) begin
        snap = sample;
        bad = 0;
        noreq = 0;
        repeat (20) begin
          tick();
          if (sample !== snap || !sample_valid) bad++;
          if (req.valid) noreq++;
        end
        chk("hold_stable", bad, 0);
        chk("hold_noreq", noreq, 0);
      end
      sample_ready = 1'b1;
      tick();
      sample_ready = 1'b0;
      if (cur == 1) begin
        chk("resume_req", req.valid, 1);
        chk("resume_addr", req.addr, Base + 48'd16);
      end
    end
    sample_ready = 1'b1;
    err_idx = -1;
    wait_samples(8, 20, "sweep1_count");
    for (int i = 0; i < 4; i++) cmp_row(4 + i, 4 + i);

    // sweep 2: triggers while busy are dropped and counted, saturating
    hold = 1;
    pulse();
    tick();
    repeat (3) begin
      pulse();
      tick();
    end
    chk("overrun_3", overrun, 3);
    trigger = 1'b1;
    repeat (70000) tick();
    trigger = 1'b0;
    tick();
    chk("overrun_sat", overrun, 16'hFFFF);
    chk("overrun_still_busy", busy, 1);
    hold = 0;
    wait_samples(12, 50, "sweep2_count");
    repeat (10) tick();
    chk("sweep2_single", got_q.size(), 12);
    chk("sweep2_idle", busy, 0);
    for (int i = 0; i < 4; i++) cmp_row(8 + i, 8 + i);

    // reset while a request is outstanding
    hold = 1;
    pulse();
    chk("prerst_req_valid", req.valid, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_req_valid", req.valid, 0);
    chk("mrst_sample_valid", sample_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_overrun", overrun, 0);
    chk("mrst_sample", sample, 0);
    tick();
    rst_n = 1'b1;
    hold = 0;
    tick();
    pulse();
    wait_samples(16, 50, "postrst_count");
    if (got_q.size() > 12) begin
      chk("postrst_idx", got_q[12].idx, 0);
      chk("postrst_seq", got_q[12].seq, 0);
      chk("postrst_value", got_q[12].value, 0);
    end

    // enable dropped right after the trigger: the sweep still completes
    pulse();
    enable = 1'b0;
    wait_samples(20, 50, "endrop_count");
    if (got_q.size() >= 20) begin
      chk("endrop_seq", got_q[16].seq, 1);
      chk("endrop_last_idx", got_q[19].idx, 3);
    end
    repeat (5) tick();
    enable = 1'b1;

    // period timer: sweeps every 50 cycles
    n0 = start_q.size();
    g0 = got_q.size();
    period = 32'd50;
    repeat (175) tick();
    period = '0;
    repeat (20) tick();
    chk("timer_sweeps", start_q.size() - n0, 3);
    if (start_q.size() - n0 >= 3) begin
      chk("timer_gap1", start_q[n0+1] - start_q[n0], 50);
      chk("timer_gap2", start_q[n0+2] - start_q[n0+1], 50);
    end
    chk("timer_overrun", overrun, 0);
    chk("timer_samples", got_q.size() - g0, 12);
    if (got_q.size() >= g0 + 12)
      for (int s = 0; s < 3; s++)
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("timer_seq_s%0d_i%0d", s, i), got_q[g0+4*s+i].seq, 2 + s);
          chk($sformatf("timer_idx_s%0d_i%0d", s, i), got_q[g0+4*s+i].idx, i);
        end

    chk("no_req_while_pending", overlap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
